// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree: request format and
// sizing helpers used by rx/tx stages and arbiters.
package fractal_sync_pkg;

   localparam int unsigned AGGR_W          = 3;
   localparam int unsigned ID_W            = 8;
   localparam int          N_PORTS_DEFAULT = 2;

   typedef struct packed {
      logic [AGGR_W-1:0] aggr;
      logic [ID_W-1:0]   id;
   } fsync_sig_t;

   typedef struct packed {
      logic       sync;
      fsync_sig_t sig;
   } fsync_req_t;

   // Index width for n ports; a single port still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fractal_sync_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after ptr, then moves
// ptr just past the winner so every requester is served within N grants.
module fractal_sync_rr_arb
   import fractal_sync_pkg::*;
#(
   parameter  int N     = N_PORTS_DEFAULT,
   localparam int IDX_W = idx_width(N)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [N-1:0]     req,
   input  logic             en,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0] ptr;
   logic             found;

   // NOTE: every output gets a default before the loop so no path leaves a
   // value unassigned; that is what keeps this block free of latches.
   always_comb begin
      int             k;
      logic [IDX_W-1:0] k_idx;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k       = 0;
      k_idx   = '0;
      for (int i = 0; i < N; i++) begin
         k = int'(ptr) + i;
         if (k >= N) k = k - N;
         k_idx = IDX_W'(k);
         if (en && req[k_idx] && !found) begin
            gnt[k_idx] = 1'b1;
            gnt_idx    = k_idx;
            found      = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/fractal_sync_tx.sv
// Pops one request per cycle from N_PORTS rx queues (round-robin) and forwards
// it to the parent level as a single-cycle sync pulse with its aggr/id fields.
module fractal_sync_tx #(
   parameter  type fsync_req_t = fractal_sync_pkg::fsync_req_t,
   parameter  int  N_PORTS     = fractal_sync_pkg::N_PORTS_DEFAULT,
   parameter  bit  COMB_OUT    = 1'b0,
   localparam int  IDX_W       = fractal_sync_pkg::idx_width(N_PORTS)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         en_i,
   input  logic       [N_PORTS-1:0]     empty_i,
   input  fsync_req_t [N_PORTS-1:0]     req_i,
   output logic       [N_PORTS-1:0]     pop_o,
   output fsync_req_t                   req_o,
   output logic       [IDX_W-1:0]       gnt_idx_o,
   output logic                         busy_o
);

   localparam int SIG_W = $bits(fsync_req_t) - 1;

   logic [N_PORTS-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               granted;
   logic [SIG_W-1:0]   sel_sig;
   logic [SIG_W-1:0]   sig_q;
   logic               sync_q;
   logic [IDX_W-1:0]   idx_q;

   fractal_sync_rr_arb #(
      .N (N_PORTS)
   ) u_arb (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .req     (~empty_i),
      .en      (en_i),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign granted   = |gnt;
   assign pop_o     = gnt;
   assign busy_o    = ~&empty_i;
   assign gnt_idx_o = idx_q;

   // One-hot grant makes an AND-OR mux sufficient for the head selection.
   always_comb begin
      sel_sig = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (gnt[k]) sel_sig = sel_sig | req_i[k].sig;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= 1'b0;
         sig_q  <= '0;
         idx_q  <= '0;
      end else begin
         sync_q <= granted;
         if (granted) begin
            sig_q <= sel_sig;
            idx_q <= gnt_idx;
         end
      end
   end

   // sig stays at the last forwarded value between pulses in both modes.
   always_comb begin
      req_o = '0;
      if (COMB_OUT) begin
         req_o.sync = granted;
         req_o.sig  = granted ? sel_sig : sig_q;
      end else begin
         req_o.sync = sync_q;
         req_o.sig  = sig_q;
      end
   end

endmodule

// File: tb/tb_fractal_sync_tx.sv
// Bench for fractal_sync_tx: N=2 registered-output and N=4 combinational-output
// instances, checked by a vector table, hand sequences and a reference model.
module tb_fractal_sync_tx;
   import fractal_sync_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;

   logic       [1:0] empty2 = '1;
   fsync_req_t [1:0] req2   = '0;
   logic       [1:0] pop2;
   fsync_req_t       req_o2;
   logic       [0:0] idx2;
   logic             busy2;

   logic       [3:0] empty4 = '1;
   fsync_req_t [3:0] req4   = '0;
   logic       [3:0] pop4;
   fsync_req_t       req_o4;
   logic       [1:0] idx4;
   logic             busy4;

   int n_vec = 0;
   int n_err = 0;

   int         m2_ptr, m4_ptr, m2_idx, m4_idx;
   logic       m2_sync;
   fsync_sig_t m2_sig, m4_sig;

   typedef struct {
      logic       en;
      logic [1:0] empty;
      int         a0, i0, a1, i1;
      logic [1:0] pop;
      logic       sync;
      int         aggr, id;
      logic       idx;
      logic       busy;
   } vec_t;

   vec_t tbl[15];

   fractal_sync_tx #(.N_PORTS(2), .COMB_OUT(1'b0)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .empty_i(empty2), .req_i(req2),
      .pop_o(pop2), .req_o(req_o2), .gnt_idx_o(idx2), .busy_o(busy2)
   );

   fractal_sync_tx #(.N_PORTS(4), .COMB_OUT(1'b1)) dut4 (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .empty_i(empty4), .req_i(req4),
      .pop_o(pop4), .req_o(req_o4), .gnt_idx_o(idx4), .busy_o(busy4)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic fsync_req_t mko(input logic s, input int a, input int i);
      fsync_req_t r;
      r.sync     = s;
      r.sig.aggr = AGGR_W'(a);
      r.sig.id   = ID_W'(i);
      return r;
   endfunction

   function automatic fsync_req_t mkr(input int a, input int i);
      return mko(1'b1, a, i);
   endfunction

   function automatic vec_t mkv(input logic e, input logic [1:0] em, input int a0, input int i0,
                                input int a1, input int i1, input logic [1:0] p, input logic s,
                                input int ag, input int id, input logic ix, input logic b);
      vec_t v;
      v.en = e; v.empty = em; v.a0 = a0; v.i0 = i0; v.a1 = a1; v.i1 = i1;
      v.pop = p; v.sync = s; v.aggr = ag; v.id = id; v.idx = ix; v.busy = b;
      return v;
   endfunction

   // First non-empty port scanning from ptr, or -1 when nothing may be granted.
   function automatic int pick(input int n, input int ptr, input logic [3:0] empty, input logic en_v);
      for (int i = 0; i < n; i++) begin
         int k = (ptr + i) % n;
         if (en_v && !empty[k]) return k;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m2_ptr = 0; m4_ptr = 0; m2_idx = 0; m4_idx = 0;
      m2_sync = 1'b0; m2_sig = '0; m4_sig = '0;
   endtask

   // Compare both DUTs with the model for the current inputs, then advance one clock.
   task automatic model_step();
      int g2, g4;
      fsync_req_t e2, e4;
      g2 = pick(2, m2_ptr, {2'b11, empty2}, en);
      g4 = pick(4, m4_ptr, empty4, en);
      e2 = '0; e2.sync = m2_sync; e2.sig = m2_sig;
      e4 = '0; e4.sync = (g4 >= 0); e4.sig = (g4 >= 0) ? req4[g4].sig : m4_sig;
      check("m2_pop", 32'(pop2), (g2 >= 0) ? (32'd1 << g2) : 32'd0);
      check("m2_busy", 32'(busy2), 32'(empty2 != 2'b11));
      check("m2_req", 32'(req_o2), 32'(e2));
      check("m2_idx", 32'(idx2), 32'(m2_idx));
      check("m4_pop", 32'(pop4), (g4 >= 0) ? (32'd1 << g4) : 32'd0);
      check("m4_busy", 32'(busy4), 32'(empty4 != 4'hF));
      check("m4_req", 32'(req_o4), 32'(e4));
      check("m4_idx", 32'(idx4), 32'(m4_idx));
      m2_sync = (g2 >= 0);
      if (g2 >= 0) begin m2_sig = req2[g2].sig; m2_idx = g2; m2_ptr = (g2 + 1) % 2; end
      if (g4 >= 0) begin m4_sig = req4[g4].sig; m4_idx = g4; m4_ptr = (g4 + 1) % 4; end
      @(negedge clk);
   endtask

   initial begin
      //            en    empty  a0 i0 a1 i1  pop   sync ag id  idx   busy
      tbl[0]  = mkv(1'b1, 2'b11, 0, 0, 0, 0,  2'b00, 1'b0, 0, 0,  1'b0, 1'b0);
      tbl[1]  = mkv(1'b1, 2'b01, 0, 0, 3, 5,  2'b10, 1'b0, 0, 0,  1'b0, 1'b1);
      tbl[2]  = mkv(1'b1, 2'b11, 0, 0, 0, 0,  2'b00, 1'b1, 3, 5,  1'b1, 1'b0);
      tbl[3]  = mkv(1'b1, 2'b11, 0, 0, 0, 0,  2'b00, 1'b0, 3, 5,  1'b1, 1'b0);
      tbl[4]  = mkv(1'b1, 2'b00, 1, 10, 2, 20, 2'b01, 1'b0, 3, 5, 1'b1, 1'b1);
      tbl[5]  = mkv(1'b1, 2'b00, 1, 11, 2, 21, 2'b10, 1'b1, 1, 10, 1'b0, 1'b1);
      tbl[6]  = mkv(1'b1, 2'b00, 4, 12, 5, 22, 2'b01, 1'b1, 2, 21, 1'b1, 1'b1);
      tbl[7]  = mkv(1'b0, 2'b00, 4, 12, 5, 22, 2'b00, 1'b1, 4, 12, 1'b0, 1'b1);
      tbl[8]  = mkv(1'b0, 2'b00, 4, 12, 5, 22, 2'b00, 1'b0, 4, 12, 1'b0, 1'b1);
      tbl[9]  = mkv(1'b0, 2'b00, 4, 12, 5, 22, 2'b00, 1'b0, 4, 12, 1'b0, 1'b1);
      tbl[10] = mkv(1'b1, 2'b00, 6, 30, 7, 40, 2'b10, 1'b0, 4, 12, 1'b0, 1'b1);
      tbl[11] = mkv(1'b1, 2'b10, 0, 50, 0, 0,  2'b01, 1'b1, 7, 40, 1'b1, 1'b1);
      tbl[12] = mkv(1'b1, 2'b10, 1, 51, 0, 0,  2'b01, 1'b1, 0, 50, 1'b0, 1'b1);
      tbl[13] = mkv(1'b1, 2'b11, 0, 0, 0, 0,  2'b00, 1'b1, 1, 51, 1'b0, 1'b0);
      tbl[14] = mkv(1'b1, 2'b11, 0, 0, 0, 0,  2'b00, 1'b0, 1, 51, 1'b0, 1'b0);

      model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_req", 32'(req_o2), 32'd0);
      check("rst_idx", 32'(idx2), 32'd0);
      check("rst_pop", 32'(pop2), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         #1;
         check("idle_pop", 32'(pop2), 32'd0);
         check("idle_req", 32'(req_o2), 32'd0);
         check("idle_busy", 32'(busy2), 32'd0);
         model_step();
      end

      for (int i = 0; i < 15; i++) begin
         en      = tbl[i].en;
         empty2  = tbl[i].empty;
         req2[0] = mkr(tbl[i].a0, tbl[i].i0);
         req2[1] = mkr(tbl[i].a1, tbl[i].i1);
         #1;
         check($sformatf("tbl%0d_pop", i), 32'(pop2), 32'(tbl[i].pop));
         check($sformatf("tbl%0d_busy", i), 32'(busy2), 32'(tbl[i].busy));
         check($sformatf("tbl%0d_req", i), 32'(req_o2), 32'(mko(tbl[i].sync, tbl[i].aggr, tbl[i].id)));
         check($sformatf("tbl%0d_idx", i), 32'(idx2), 32'(tbl[i].idx));
         model_step();
      end

      // Async reset while a pulse is on req_o, then strict rotation from port 0
      en = 1'b1; empty2 = 2'b00; req2[0] = mkr(1, 1); req2[1] = mkr(2, 2);
      #1;
      model_step();
      #1;
      check("pre_rst_sync", 32'(req_o2.sync), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_kill_req", 32'(req_o2), 32'd0);
      check("rst_kill_idx", 32'(idx2), 32'd0);
      model_reset();
      empty2 = 2'b11;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         empty2 = 2'b00; req2[0] = mkr(i, 100 + i); req2[1] = mkr(7 - i, 200 + i);
         #1;
         check("rot_pop", 32'(pop2), (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i > 0) begin
            check("rot_sync", 32'(req_o2.sync), 32'd1);
            check("rot_idx", 32'(idx2), 32'((i - 1) % 2));
         end
         model_step();
      end
      empty2 = 2'b11;
      #1;
      check("rot_last_sync", 32'(req_o2.sync), 32'd1);
      check("rot_last_idx", 32'(idx2), 32'd1);
      model_step();

      // Pointer wrap on the 4-port, combinational-output instance
      empty4 = 4'b1011; req4[2] = mkr(3, 22);
      #1; check("wrap_pop_a", 32'(pop4), 32'b0100); model_step();
      empty4 = 4'b0110; req4[3] = mkr(5, 33); req4[0] = mkr(6, 44);
      #1;
      check("wrap_pop_b", 32'(pop4), 32'b1000);
      check("wrap_req_b", 32'(req_o4), 32'(mko(1'b1, 5, 33)));
      check("wrap_idx_b", 32'(idx4), 32'd2);
      model_step();
      #1;
      check("wrap_pop_c", 32'(pop4), 32'b0001);
      check("wrap_req_c", 32'(req_o4), 32'(mko(1'b1, 6, 44)));
      check("wrap_idx_c", 32'(idx4), 32'd3);
      model_step();
      empty4 = 4'b1100; req4[1] = mkr(2, 55);
      #1;
      check("wrap_pop_d", 32'(pop4), 32'b0010);
      check("wrap_idx_d", 32'(idx4), 32'd0);
      model_step();
      empty4 = 4'b1111;
      #1;
      check("wrap_req_e", 32'(req_o4), 32'(mko(1'b0, 2, 55)));
      check("wrap_idx_e", 32'(idx4), 32'd1);
      model_step();

      // Randomized traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         en     = ($urandom_range(0, 7) != 0);
         empty2 = 2'($urandom_range(0, 3));
         empty4 = 4'($urandom_range(0, 15));
         for (int k = 0; k < 2; k++) req2[k] = mkr($urandom_range(0, 7), $urandom_range(0, 255));
         for (int k = 0; k < 4; k++) req4[k] = mkr($urandom_range(0, 7), $urandom_range(0, 255));
         #1;
         model_step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
